// File: rtl/mdu_pkg.sv
// Shared encodings for the sequential multiplier: Funct3 opcodes and FSM states.
package mdu_pkg;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Undefined encodings (1xx) behave as a plain low-half multiply.
    function automatic logic [2:0] norm_funct3(input logic [2:0] f3);
        return f3[2] ? MUL : f3;
    endfunction

endpackage

// File: rtl/mulseq_if.sv
// Operand/result handshake bundle between a requester and the multiplier.
interface mulseq_if #(
    parameter int XLEN = 32
);
    logic                InValid;
    logic                InReady;
    logic [XLEN-1:0]     SrcA;
    logic [XLEN-1:0]     SrcB;
    logic [2:0]          Funct3;
    logic                OutValid;
    logic                OutReady;
    logic [2*XLEN-1:0]   Prod;
    logic [XLEN-1:0]     Result;

    modport master (
        output InValid, SrcA, SrcB, Funct3, OutReady,
        input  InReady, OutValid, Prod, Result
    );

    modport slave (
        input  InValid, SrcA, SrcB, Funct3, OutReady,
        output InReady, OutValid, Prod, Result
    );
endinterface

// File: rtl/mulseq_step.sv
// One radix iteration: adds |A| times a RADIX_BITS digit of |B| at bit position pos_i.
module mulseq_step #(
    parameter int XLEN       = 32,
    parameter int RADIX_BITS = 2,
    parameter int POS_W      = 6
) (
    input  logic [2*XLEN-1:0]     acc_i,
    input  logic [XLEN-1:0]       mag_a_i,
    input  logic [RADIX_BITS-1:0] digit_i,
    input  logic [POS_W-1:0]      pos_i,
    output logic [2*XLEN-1:0]     acc_o
);
    localparam int PW = XLEN + RADIX_BITS;

    logic [PW-1:0]     partial;
    logic [2*XLEN-1:0] partial_ext;

    // Partial product never exceeds XLEN+RADIX_BITS bits, so widening then shifting is exact.
    always_comb begin
        partial     = {{RADIX_BITS{1'b0}}, mag_a_i} * {{XLEN{1'b0}}, digit_i};
        partial_ext = {{(XLEN-RADIX_BITS){1'b0}}, partial} << pos_i;
        acc_o       = acc_i + partial_ext;
    end
endmodule

// File: rtl/mulseq.sv
// Sequential radix-2^RADIX_BITS multiplier for RISC-V mul/mulh/mulhsu/mulhu.
//
//   state | meaning
//   IDLE  | InReady high, waiting for an operation
//   BUSY  | one digit retired per cycle; extra cycle at terminal count
//   FIX   | apply result sign to the magnitude product
//   DONE  | OutValid high, result held until OutReady
module mulseq
    import mdu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int RADIX_BITS = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    Flush,
    mulseq_if.slave bus
);
    localparam int N     = XLEN / RADIX_BITS;
    localparam int CNT_W = $clog2(N + 1);
    localparam int POS_W = $clog2(2 * XLEN);

    if ((XLEN % RADIX_BITS) != 0) begin : g_bad_radix
        $error("mulseq: XLEN must be a multiple of RADIX_BITS");
    end
    if (!(RADIX_BITS == 1 || RADIX_BITS == 2 || RADIX_BITS == 4 || RADIX_BITS == 8)) begin : g_bad_radix_val
        $error("mulseq: RADIX_BITS must be 1, 2, 4 or 8");
    end
    if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
        $error("mulseq: XLEN must be 32 or 64");
    end

    state_e            state_q, state_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic [XLEN-1:0]   mag_a_q, mag_a_d;
    logic [XLEN-1:0]   mag_b_q, mag_b_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [POS_W-1:0]  pos_q, pos_d;

    logic [2*XLEN-1:0] step_acc;
    logic              accept;
    logic [2:0]        f3_in;
    logic              a_signed;
    logic              b_signed;

    mulseq_step #(
        .XLEN       (XLEN),
        .RADIX_BITS (RADIX_BITS),
        .POS_W      (POS_W)
    ) u_step (
        .acc_i   (acc_q),
        .mag_a_i (mag_a_q),
        .digit_i (mag_b_q[RADIX_BITS-1:0]),
        .pos_i   (pos_q),
        .acc_o   (step_acc)
    );

    // Next-state and datapath; the counter stays in BUSY one extra cycle at zero so latency is N+2.
    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        pos_d    = pos_q;

        f3_in    = norm_funct3(bus.Funct3);
        a_signed = (f3_in == MULH) || (f3_in == MULHSU);
        b_signed = (f3_in == MULH);
        accept   = bus.InValid && (state_q == ST_IDLE) && !Flush;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    funct3_d = f3_in;
                    sign_a_d = a_signed && bus.SrcA[XLEN-1];
                    sign_b_d = b_signed && bus.SrcB[XLEN-1];
                    // Negating 0x80..0 yields 0x80..0, which read unsigned is the exact magnitude.
                    mag_a_d  = (a_signed && bus.SrcA[XLEN-1]) ? (~bus.SrcA + XLEN'(1)) : bus.SrcA;
                    mag_b_d  = (b_signed && bus.SrcB[XLEN-1]) ? (~bus.SrcB + XLEN'(1)) : bus.SrcB;
                    acc_d    = '0;
                    cnt_d    = CNT_W'(N);
                    pos_d    = '0;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    acc_d   = step_acc;
                    mag_b_d = mag_b_q >> RADIX_BITS;
                    cnt_d   = cnt_q - CNT_W'(1);
                    pos_d   = pos_q + POS_W'(RADIX_BITS);
                end
            end
            ST_FIX: begin
                if (sign_a_q ^ sign_b_q) begin
                    acc_d = ~acc_q + (2*XLEN)'(1);
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.OutReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (Flush) begin
            state_d = ST_IDLE;
        end
    end

    // State registers; reset wins over Flush and InValid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            funct3_q <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            pos_q    <= '0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            pos_q    <= pos_d;
        end
    end

    // Outputs come straight from state and accumulator so they hold stable in DONE.
    always_comb begin
        bus.InReady  = (state_q == ST_IDLE);
        bus.OutValid = (state_q == ST_DONE);
        bus.Prod     = acc_q;
        bus.Result   = (funct3_q == MUL) ? acc_q[XLEN-1:0] : acc_q[2*XLEN-1:XLEN];
    end
endmodule

// File: tb/tb_mulseq.sv
// Bench for mulseq: five configurations driven in lockstep, checked against a plain-arithmetic model.
module tb_mulseq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n     = 1'b0;
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  funct3    = 3'b000;
    logic [63:0] src_a     = '0;
    logic [63:0] src_b     = '0;

    int checks = 0;
    int errors = 0;

    logic         ov     [5];
    logic         ir     [5];
    logic [127:0] prod_w [5];
    logic [63:0]  res_w  [5];

    int           cap_lat  [5];
    logic [127:0] cap_prod [5];
    logic [63:0]  cap_res  [5];

    int xl_of    [5] = '{32, 32, 32, 32, 64};
    int radix_of [5] = '{2, 1, 4, 8, 2};

    mulseq_if #(.XLEN(32)) if0 ();
    mulseq_if #(.XLEN(32)) if1 ();
    mulseq_if #(.XLEN(32)) if2 ();
    mulseq_if #(.XLEN(32)) if3 ();
    mulseq_if #(.XLEN(64)) if4 ();

    assign if0.InValid = in_valid; assign if0.SrcA = src_a[31:0]; assign if0.SrcB = src_b[31:0];
    assign if0.Funct3 = funct3;    assign if0.OutReady = out_ready;
    assign if1.InValid = in_valid; assign if1.SrcA = src_a[31:0]; assign if1.SrcB = src_b[31:0];
    assign if1.Funct3 = funct3;    assign if1.OutReady = out_ready;
    assign if2.InValid = in_valid; assign if2.SrcA = src_a[31:0]; assign if2.SrcB = src_b[31:0];
    assign if2.Funct3 = funct3;    assign if2.OutReady = out_ready;
    assign if3.InValid = in_valid; assign if3.SrcA = src_a[31:0]; assign if3.SrcB = src_b[31:0];
    assign if3.Funct3 = funct3;    assign if3.OutReady = out_ready;
    assign if4.InValid = in_valid; assign if4.SrcA = src_a;       assign if4.SrcB = src_b;
    assign if4.Funct3 = funct3;    assign if4.OutReady = out_ready;

    assign ov[0] = if0.OutValid; assign ir[0] = if0.InReady;
    assign prod_w[0] = {64'd0, if0.Prod}; assign res_w[0] = {32'd0, if0.Result};
    assign ov[1] = if1.OutValid; assign ir[1] = if1.InReady;
    assign prod_w[1] = {64'd0, if1.Prod}; assign res_w[1] = {32'd0, if1.Result};
    assign ov[2] = if2.OutValid; assign ir[2] = if2.InReady;
    assign prod_w[2] = {64'd0, if2.Prod}; assign res_w[2] = {32'd0, if2.Result};
    assign ov[3] = if3.OutValid; assign ir[3] = if3.InReady;
    assign prod_w[3] = {64'd0, if3.Prod}; assign res_w[3] = {32'd0, if3.Result};
    assign ov[4] = if4.OutValid; assign ir[4] = if4.InReady;
    assign prod_w[4] = if4.Prod;          assign res_w[4] = if4.Result;

    mulseq #(.XLEN(32), .RADIX_BITS(2)) u0 (.clk(clk), .reset(rst_n), .Flush(flush), .bus(if0.slave));
    mulseq #(.XLEN(32), .RADIX_BITS(1)) u1 (.clk(clk), .reset(rst_n), .Flush(flush), .bus(if1.slave));
    mulseq #(.XLEN(32), .RADIX_BITS(4)) u2 (.clk(clk), .reset(rst_n), .Flush(flush), .bus(if2.slave));
    mulseq #(.XLEN(32), .RADIX_BITS(8)) u3 (.clk(clk), .reset(rst_n), .Flush(flush), .bus(if3.slave));
    mulseq #(.XLEN(64), .RADIX_BITS(2)) u4 (.clk(clk), .reset(rst_n), .Flush(flush), .bus(if4.slave));

    // Reference: extend each operand per its signedness to 128 bits and multiply modulo 2^128.
    function automatic logic [127:0] ref_prod(input int xl, input logic [2:0] f3,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ea, eb, p;
        bit sa, sb;
        sa = (f3 == 3'b001) || (f3 == 3'b010);
        sb = (f3 == 3'b001);
        if (xl == 32) begin
            ea = sa ? 128'($signed(a[31:0])) : 128'(a[31:0]);
            eb = sb ? 128'($signed(b[31:0])) : 128'(b[31:0]);
        end else begin
            ea = sa ? 128'($signed(a)) : 128'(a);
            eb = sb ? 128'($signed(b)) : 128'(b);
        end
        p = ea * eb;
        return (xl == 32) ? {64'd0, p[63:0]} : p;
    endfunction

    function automatic logic [63:0] ref_res(input int xl, input logic [2:0] f3, input logic [127:0] p);
        bit high;
        high = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b011);
        if (xl == 32) return high ? {32'd0, p[63:32]} : {32'd0, p[31:0]};
        return high ? p[127:64] : p[63:0];
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'h8000_0000_0000_0000;
            2: return 64'h0000_0000_8000_0000;
            3: return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation to every configuration, wait for all results, check latency and values.
    task automatic run_op(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                          input bit handshake);
        int  k;
        bit  all_seen;
        logic [127:0] ep;
        for (int i = 0; i < 5; i++) cap_lat[i] = -1;
        @(negedge clk);
        chk("in_ready_before_op", ir[0], 1'b1);
        funct3 = f3; src_a = a; src_b = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        all_seen = 1'b0;
        while (!all_seen && k < 80) begin
            @(negedge clk);
            k++;
            all_seen = 1'b1;
            for (int i = 0; i < 5; i++) begin
                if (ov[i] && cap_lat[i] < 0) begin
                    cap_lat[i]  = k;
                    cap_prod[i] = prod_w[i];
                    cap_res[i]  = res_w[i];
                end
                if (cap_lat[i] < 0) all_seen = 1'b0;
            end
        end
        for (int i = 0; i < 5; i++) begin
            ep = ref_prod(xl_of[i], f3, a, b);
            chk($sformatf("latency[%0d] f3=%0d", i, f3), 128'(cap_lat[i]), 128'(xl_of[i] / radix_of[i] + 2));
            chk($sformatf("prod[%0d] f3=%0d a=%0h b=%0h", i, f3, a, b), cap_prod[i], ep);
            chk($sformatf("result[%0d] f3=%0d a=%0h b=%0h", i, f3, a, b), 128'(cap_res[i]),
                128'(ref_res(xl_of[i], f3, ep)));
        end
        if (handshake) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk("in_ready_after_handshake", ir[0], 1'b1);
            chk("out_valid_after_handshake", ov[0], 1'b0);
        end
    endtask

    initial begin
        int seen;

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_in_ready", ir[0], 1'b1);
        chk("reset_out_valid", ov[0], 1'b0);
        chk("reset_prod_zero", prod_w[0], 128'd0);

        // Basic mul with negative-looking multiplier
        run_op(3'b000, 64'd7, 64'h0000_0000_FFFF_FFFD, 1'b1);
        chk("mul7_result", 128'(cap_res[0]), 128'h FFFF_FFEB);
        chk("mul7_latency", 128'(cap_lat[0]), 128'd18);

        // Most-negative operands through mulh
        run_op(3'b001, 64'h8000_0000, 64'h8000_0000, 1'b1);
        chk("mulh_minneg_prod", cap_prod[0], 128'h4000_0000_0000_0000);
        chk("mulh_minneg_result", 128'(cap_res[0]), 128'h4000_0000);

        // mulhsu / mulhu with all-ones operands
        run_op(3'b010, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1);
        chk("mulhsu_prod", cap_prod[0], 128'hFFFF_FFFF_0000_0001);
        chk("mulhsu_result", 128'(cap_res[0]), 128'hFFFF_FFFF);
        run_op(3'b011, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1);
        chk("mulhu_result", 128'(cap_res[0]), 128'hFFFF_FFFE);

        // Undefined Funct3 behaves as mul; zero operand keeps full latency
        run_op(3'b110, 64'h1234_5678, 64'h9ABC_DEF0, 1'b1);
        run_op(3'b000, 64'd0, 64'h0001_2345, 1'b1);

        // Hold in DONE with OutReady low, then handshake while InValid is also high
        run_op(3'b001, 64'hFFFF_FFF0, 64'h0000_0123, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("hold_prod_c%0d", c), prod_w[0], cap_prod[0]);
            chk($sformatf("hold_in_ready_c%0d", c), ir[0], 1'b0);
            chk($sformatf("hold_out_valid_c%0d", c), ov[0], 1'b1);
        end
        funct3 = 3'b000; src_a = 64'd3; src_b = 64'd5;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        chk("done_no_accept_in_ready", ir[0], 1'b1);
        chk("done_no_accept_out_valid", ov[0], 1'b0);

        // Flush with InValid in IDLE does not accept
        funct3 = 3'b000; src_a = 64'd2; src_b = 64'd2;
        in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_no_accept", ir[0], 1'b1);

        // Flush in the seventh BUSY cycle
        funct3 = 3'b000; src_a = 64'd11; src_b = 64'd13; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        seen = 0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (ov[0]) seen++;
        end
        chk("busy_in_ready_low", ir[0], 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy_idle", ir[0], 1'b1);
        chk("flush_busy_out_valid", ov[0], 1'b0);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (ov[0]) seen++;
        end
        chk("flush_out_valid_never", 128'(seen), 128'd0);
        run_op(3'b000, 64'd3, 64'd5, 1'b1);
        chk("after_flush_result", 128'(cap_res[0]), 128'd15);
        chk("after_flush_latency", 128'(cap_lat[0]), 128'd18);

        // Reset asserted while in FIX (17 edges after accept for N=16)
        funct3 = 3'b001; src_a = 64'hFFFF_FFF9; src_b = 64'd11; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= 17; k++) @(negedge clk);
        chk("fix_out_valid_low", ov[0], 1'b0);
        chk("fix_in_ready_low", ir[0], 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("fix_reset_out_valid", ov[0], 1'b0);
        chk("fix_reset_in_ready", ir[0], 1'b1);
        chk("fix_reset_acc_zero", prod_w[0], 128'd0);

        // Random sweep across all configurations
        for (int t = 0; t < 30; t++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mulseq.md
MULSEQ -- requirements
Module: mulseq

Interface
REQ-001 Parameter: XLEN, default 32, datapath width (32 or 64).
REQ-002 Parameter: RADIX_BITS, default 2, multiplier bits retired per iteration (1, 2, 4 or 8; SHALL divide XLEN).
REQ-003 Port: clk  input  1  single clock, all state rising-edge triggered.
REQ-004 Port: reset  input  1  synchronous, active-low reset.
REQ-005 Port: Flush  input  1  synchronous abort of any in-flight operation.
REQ-006 Port: InValid  input  1  operands and Funct3 valid this cycle.
REQ-007 Port: InReady  output  1  block can accept an operation.
REQ-008 Port: SrcA  input  XLEN  multiplicand (rs1).
REQ-009 Port: SrcB  input  XLEN  multiplier (rs2).
REQ-010 Port: Funct3  input  3  000 mul, 001 mulh, 010 mulhsu, 011 mulhu; others treated as 000.
REQ-011 Port: OutValid  output  1  Prod/Result valid.
REQ-012 Port: OutReady  input  1  consumer takes result.
REQ-013 Port: Prod  output  2*XLEN  full product.
REQ-014 Port: Result  output  XLEN  Prod low half for mul, high half otherwise.

Function
REQ-015 FSM states SHALL be IDLE, BUSY, FIX, DONE; InReady = (state == IDLE).
REQ-016 Accept = InValid & InReady & ~Flush; on accept, latch Funct3 and operand signs (A signed for mulh/mulhsu, B signed for mulh), load operand magnitudes (two's-complement absolute value when signed and MSB set), clear accumulator, load counter with N = XLEN/RADIX_BITS, go BUSY.
REQ-017 BUSY: each cycle add |A| times low RADIX_BITS of remaining |B| into accumulator at the current bit position, shift |B| right by RADIX_BITS, decrement counter; after N cycles go FIX.
REQ-018 FIX: negate 2*XLEN accumulator iff sign(A) XOR sign(B) latched as 1; go DONE.
REQ-019 DONE: OutValid = 1; Prod/Result held stable until OutValid & OutReady, then IDLE.
REQ-020 Latency: OutValid first asserted exactly N+2 cycles after the accepting edge; fixed, independent of operand values.
REQ-021 Most-negative operand (0x80..0) SHALL produce its exact magnitude 2^(XLEN-1) via XLEN-bit unsigned magnitude path.
REQ-022 Zero operand SHALL NOT shorten latency.
REQ-023 Flush in any state SHALL force IDLE next cycle, clear OutValid, discard result; Flush with InValid in IDLE: no accept.
REQ-024 Outside DONE, OutValid = 0; Prod/Result are don't-care but SHALL NOT be X.
REQ-025 No new accept while DONE, even if OutReady is high that cycle; earliest next accept is the cycle after the handshake.

Reset
REQ-026 reset low at a clock edge SHALL force IDLE, OutValid 0, InReady 1 next cycle, accumulator/counter/latched Funct3 zero; overrides Flush and InValid; mid-operation reset discards the operation.

Structure
REQ-027 Package mdu_pkg SHALL hold the Funct3 encodings (MUL, MULH, MULHSU, MULHU) and the FSM state enum.
REQ-028 One sub-module mulseq_step: combinational radix step (accumulator, |A|, RADIX_BITS digit -> next accumulator); registers live in mulseq.
REQ-029 Elaboration SHALL fail if XLEN mod RADIX_BITS != 0.

Verification
REQ-030 XLEN=32, RADIX_BITS=2, mul 7 x 0xFFFFFFFD -> Result 0xFFFFFFEB, OutValid exactly 18 cycles after accept.
REQ-031 mulh 0x80000000 x 0x80000000 -> Prod 0x40000000_00000000, Result 0x40000000.
REQ-032 mulhsu 0xFFFFFFFF x 0xFFFFFFFF -> Prod 0xFFFFFFFF_00000001, Result 0xFFFFFFFF; mulhu same operands -> Result 0xFFFFFFFE.
REQ-033 OutReady held low 5 cycles in DONE -> Prod stable, InReady 0; then OutReady high -> IDLE next cycle, InReady 1.
REQ-034 Flush at BUSY cycle 7 -> OutValid never asserts, IDLE next cycle; following mul 3 x 5 -> Result 15 after 18 cycles.
REQ-035 reset low during FIX -> IDLE, OutValid 0 next cycle; sweep RADIX_BITS 1/4/8 and XLEN=64 with random operands vs reference model.
